// File: rtl/al_retire_ctrl_pkg.sv
// al_retire_ctrl_pkg: shared FSM state, sizes and derived widths for the active-list retire controller
package al_retire_ctrl_pkg;
  localparam int AL_DEPTH = 16;
  localparam int AL_INDEX = 4;
  localparam int AL_CW = 4;
  localparam int AL_DW = 4;
  localparam int AL_CNTW = 3;
  typedef enum logic [1:0] {INIT, RUN, FLUSH} state_e;
  typedef logic [AL_INDEX-1:0] al_idx_t;
  typedef logic [AL_INDEX:0] al_cnt_t;
  typedef logic [AL_CNTW-1:0] al_lane_cnt_t;
endpackage

// File: rtl/al_retire_ctrl_if.sv
// al_retire_ctrl_if: commit/dispatch bus between the pipeline, the ready-bit RAM and the retire controller
interface al_retire_ctrl_if import al_retire_ctrl_pkg::*; #(
  parameter int INDEX = AL_INDEX,
  parameter int CW = AL_CW,
  parameter int CNTW = AL_CNTW
);
  logic ramReady_i;
  logic flush_i;
  logic stall_i;
  logic [CW-1:0] commitLaneActive_i;
  logic [CNTW-1:0] dispCnt_i;
  logic [CW-1:0] rdyBits_i;
  logic [CW-1:0][INDEX-1:0] rdAddr_o;
  logic [INDEX-1:0] alHead_o;
  logic [INDEX-1:0] alTail_o;
  logic [INDEX:0] alCount_o;
  logic alFull_o;
  logic alEmpty_o;
  logic [CW-1:0] commitVec_o;
  logic [CNTW-1:0] commitCnt_o;
  logic [CW-1:0] clrWe_o;
  logic [CW-1:0][INDEX-1:0] clrAddr_o;
  logic ovfErr_o;
  modport master (
    output ramReady_i, flush_i, stall_i, commitLaneActive_i, dispCnt_i, rdyBits_i,
    input rdAddr_o, alHead_o, alTail_o, alCount_o, alFull_o, alEmpty_o,
    input commitVec_o, commitCnt_o, clrWe_o, clrAddr_o, ovfErr_o
  );
  modport slave (
    input ramReady_i, flush_i, stall_i, commitLaneActive_i, dispCnt_i, rdyBits_i,
    output rdAddr_o, alHead_o, alTail_o, alCount_o, alFull_o, alEmpty_o,
    output commitVec_o, commitCnt_o, clrWe_o, clrAddr_o, ovfErr_o
  );
endinterface

// File: rtl/al_commit_prefix.sv
// al_commit_prefix: keeps the leading run of ones from lane 0 and counts it
module al_commit_prefix #(
  parameter int CW = 4,
  parameter int CNTW = 3
) (
  input  logic [CW-1:0]   mask_i,
  output logic [CW-1:0]   vec_o,
  output logic [CNTW-1:0] cnt_o
);
  logic run;
  always_comb begin
    vec_o = '0;
    cnt_o = '0;
    run = 1'b1;
    for (int i = 0; i < CW; i++) begin
      run = run & mask_i[i];
      vec_o[i] = run;
      cnt_o = cnt_o + CNTW'(run);
    end
  end
endmodule

// File: rtl/al_retire_ctrl.sv
// al_retire_ctrl: active-list head/tail/count tracking with in-order multi-lane commit
// Drives the commit-side ports of an external ready-bit RAM; holds no ready bits itself.
module al_retire_ctrl import al_retire_ctrl_pkg::*; #(
  parameter int DEPTH = AL_DEPTH,
  parameter int INDEX = AL_INDEX,
  parameter int CW = AL_CW,
  parameter int DW = AL_DW,
  parameter int CNTW = AL_CNTW
) (
  input logic clk,
  input logic reset,
  al_retire_ctrl_if.slave al
);
  state_e state_q, state_d;
  logic [INDEX-1:0] head_q, head_d, tail_q, tail_d;
  logic [INDEX:0] count_q, count_d, free;
  logic ovf_q, ovf_d, run, commit_en, disp_ovf;
  logic [CW-1:0] cand, vec;
  logic [CNTW-1:0] cnt;
  logic [CW-1:0][INDEX-1:0] rd_addr;

  // Lanes past the occupied count are masked so stale ready bits never retire
  always_comb begin
    run = state_q == RUN;
    commit_en = run && !al.stall_i && !al.flush_i;
    free = (INDEX+1)'(DEPTH) - count_q;
    for (int i = 0; i < CW; i++) begin
      rd_addr[i] = head_q + INDEX'(i);
      cand[i] = commit_en && ((INDEX+1)'(i) < count_q) && al.commitLaneActive_i[i] && al.rdyBits_i[i];
    end
  end

  al_commit_prefix #(.CW(CW), .CNTW(CNTW)) u_prefix (
    .mask_i(cand),
    .vec_o (vec),
    .cnt_o (cnt)
  );

  always_comb begin
    disp_ovf = run && !al.flush_i && (int'(al.dispCnt_i) > int'(free));
    state_d = run ? (al.flush_i ? FLUSH : RUN) : (al.ramReady_i ? RUN : INIT);
    ovf_d = ovf_q | disp_ovf;
    head_d = run ? (al.flush_i ? '0 : head_q + INDEX'(cnt)) : head_q;
    tail_d = tail_q;
    count_d = count_q;
    if (run && al.flush_i) begin
      tail_d = '0;
      count_d = '0;
    end else if (run && !disp_ovf) begin
      tail_d = tail_q + INDEX'(al.dispCnt_i);
      count_d = count_q + (INDEX+1)'(al.dispCnt_i) - (INDEX+1)'(cnt);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
    end
  end

  assign al.rdAddr_o = rd_addr;
  assign al.clrAddr_o = rd_addr;
  assign al.commitVec_o = vec;
  assign al.clrWe_o = vec;
  assign al.commitCnt_o = cnt;
  assign al.alHead_o = head_q;
  assign al.alTail_o = tail_q;
  assign al.alCount_o = count_q;
  assign al.alFull_o = int'(free) < DW;
  assign al.alEmpty_o = count_q == '0;
  assign al.ovfErr_o = ovf_q;
endmodule
